// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - decoder/datapath handshake bundle for the control sequencer
interface control_sequencer_if #(
  parameter int NUM_FUNC = 4,
  parameter int FUNC_W   = 3,
  parameter int CNT_W    = 16
);
  logic                en;
  logic [FUNC_W-1:0]   func;
  logic                halt;
  logic                resume;
  logic [NUM_FUNC-1:0] unit_done;
  logic                br_taken;
  logic [6:0]          state;
  logic [NUM_FUNC-1:0] unit_sel;
  logic                fault;
  logic [1:0]          fault_code;
  logic [CNT_W-1:0]    retired;

  modport master (
    output en, func, halt, resume, unit_done, br_taken,
    input  state, unit_sel, fault, fault_code, retired
  );

  modport slave (
    input  en, func, halt, resume, unit_done, br_taken,
    output state, unit_sel, fault, fault_code, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/exec/incpc control sequencer with watchdog and halt
module control_sequencer #(
  parameter int NUM_FUNC = 4,
  parameter int FUNC_W   = 3,
  parameter int TMO_W    = 8,
  parameter int TIMEOUT  = 200,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  control_sequencer_if.slave bus
);
  localparam logic [6:0] S_INIT   = 7'b0000001;
  localparam logic [6:0] S_FETCH  = 7'b0000010;
  localparam logic [6:0] S_DECODE = 7'b0000100;
  localparam logic [6:0] S_EXEC   = 7'b0001000;
  localparam logic [6:0] S_INCPC  = 7'b0010000;
  localparam logic [6:0] S_HALT   = 7'b0100000;
  localparam logic [6:0] S_FAULT  = 7'b1000000;

  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  // Watchdog value seen in the last permitted EXEC cycle
  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TIMEOUT - 1);

  logic [6:0]          state_q, state_d;
  logic [NUM_FUNC-1:0] sel_q, sel_d;
  logic [TMO_W-1:0]    wd_q;
  logic [1:0]          code_q, code_d;
  logic [CNT_W-1:0]    ret_q;
  logic                retire;
  logic                sel_done;
  logic                func_legal;
  logic [NUM_FUNC-1:0] func_onehot;

  // Only the done bit of the unit latched in DECODE counts
  assign sel_done    = |(bus.unit_done & sel_q);
  assign func_legal  = (bus.func != '0) && (bus.func <= FUNC_W'(NUM_FUNC));
  // Shift amount is meaningless for func=0, but the result is only used when func_legal
  assign func_onehot = NUM_FUNC'(1) << (bus.func - FUNC_W'(1));

  // Next-state decode; unit select survives only while staying in EXEC
  always_comb begin
    state_d = S_INIT;
    sel_d   = '0;
    code_d  = code_q;
    retire  = 1'b0;
    case (state_q)
      S_INIT:   state_d = bus.en ? S_FETCH : S_INIT;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (bus.halt) begin
          state_d = S_HALT;
        end else if (bus.func == '0) begin
          state_d = S_INCPC;
          retire  = 1'b1;
        end else if (func_legal) begin
          state_d = S_EXEC;
          sel_d   = func_onehot;
        end else begin
          state_d = S_FAULT;
          code_d  = CODE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (sel_done) begin
          retire  = 1'b1;
          state_d = bus.br_taken ? S_FETCH : S_INCPC;
        end else if (wd_q == WD_LAST) begin
          state_d = S_FAULT;
          code_d  = CODE_TIMEOUT;
        end else begin
          state_d = S_EXEC;
          sel_d   = sel_q;
        end
      end
      S_INCPC:  state_d = bus.en ? S_FETCH : S_INIT;
      S_HALT:   state_d = bus.resume ? S_INCPC : S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_INIT;
    endcase
  end

  // State, unit select, fault code, watchdog and retired counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sel_q   <= '0;
      code_q  <= 2'b00;
      wd_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      // Held at zero outside EXEC so every EXEC entry starts counting from 0
      wd_q    <= (state_q == S_EXEC) ? wd_q + TMO_W'(1) : '0;
      if (retire) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign bus.state      = state_q;
  assign bus.unit_sel   = sel_q;
  assign bus.fault      = (state_q == S_FAULT);
  assign bus.fault_code = code_q;
  assign bus.retired    = ret_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized scoreboard bench for control_sequencer
module tb_control_sequencer;
  localparam int NF      = 4;
  localparam int TIMEOUT = 200;

  localparam logic [6:0] INIT   = 7'b0000001;
  localparam logic [6:0] FETCH  = 7'b0000010;
  localparam logic [6:0] DECODE = 7'b0000100;
  localparam logic [6:0] EXEC   = 7'b0001000;
  localparam logic [6:0] INCPC  = 7'b0010000;
  localparam logic [6:0] HALT   = 7'b0100000;
  localparam logic [6:0] FAULT  = 7'b1000000;

  typedef struct packed {
    logic [6:0]  st;
    logic [3:0]  sel;
    logic        flt;
    logic [1:0]  code;
    logic [15:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  logic [15:0] m_ret  = '0;
  logic [1:0]  m_code = '0;
  int n_checks = 0;
  int n_pass   = 0;

  control_sequencer_if #(.NUM_FUNC(NF), .FUNC_W(3), .CNT_W(16)) bus ();

  control_sequencer #(.NUM_FUNC(NF), .FUNC_W(3), .TMO_W(8), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every cycle that has an expectation queued is compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state",      32'(bus.state),      32'(e.st));
      check("unit_sel",   32'(bus.unit_sel),   32'(e.sel));
      check("fault",      32'(bus.fault),      32'(e.flt));
      check("fault_code", 32'(bus.fault_code), 32'(e.code));
      check("retired",    32'(bus.retired),    32'(e.ret));
    end
  end

  // Inputs that the current state must ignore are randomized
  task automatic noise();
    bus.en        = 1'($urandom);
    bus.func      = 3'($urandom);
    bus.halt      = 1'($urandom);
    bus.resume    = 1'($urandom);
    bus.unit_done = 4'($urandom);
    bus.br_taken  = 1'($urandom);
  endtask

  // Record what the DUT must show during this cycle, then advance one clock
  task automatic cyc(input logic [6:0] st, input logic [3:0] sel);
    exp_t e;
    e.st   = st;
    e.sel  = sel;
    e.flt  = (st == FAULT);
    e.code = m_code;
    e.ret  = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic init_wait(input int idle);
    for (int i = 0; i < idle; i++) begin
      noise(); bus.en = 1'b0; cyc(INIT, 4'b0);
    end
    noise(); bus.en = 1'b1; cyc(INIT, 4'b0);
  endtask

  task automatic reset_seq(input int idle);
    rst = 1'b1;
    repeat (2) begin
      noise(); @(posedge clk); #1;
    end
    rst = 1'b0;
    m_ret  = '0;
    m_code = '0;
    init_wait(idle);
  endtask

  task automatic fault_hold(input int idle);
    for (int i = 0; i <= idle; i++) begin
      noise(); cyc(FAULT, 4'b0);
    end
    reset_seq(1);
  endtask

  // One instruction starting in FETCH; always leaves the DUT in FETCH.
  // done_at: EXEC cycle (1-based) with done, 0 = never; rst_at: EXEC cycle with reset, 0 = none.
  task automatic instr(input int f, input bit h, input int done_at, input bit br,
                       input int hwait, input bit en_inc, input int idle, input int rst_at);
    logic [3:0] sel;
    noise(); cyc(FETCH, 4'b0);
    noise(); bus.halt = h; bus.func = 3'(f); cyc(DECODE, 4'b0);
    if (h) begin
      for (int i = 0; i < hwait; i++) begin
        noise(); bus.resume = 1'b0; cyc(HALT, 4'b0);
      end
      noise(); bus.resume = 1'b1; cyc(HALT, 4'b0);
    end else if (f == 0) begin
      m_ret = m_ret + 16'd1;
    end else if (f > NF) begin
      m_code = 2'b01;
      fault_hold(idle);
      return;
    end else begin
      sel = 4'b0001 << (f - 1);
      for (int i = 1; i <= TIMEOUT; i++) begin
        noise();
        bus.unit_done = (i % 2 == 1) ? ~sel : (4'($urandom) & ~sel);
        if (i == rst_at) begin
          rst = 1'b1;
          cyc(EXEC, sel);
          rst = 1'b0;
          m_ret  = '0;
          m_code = '0;
          init_wait(idle);
          return;
        end
        if (i == done_at) begin
          bus.unit_done = bus.unit_done | sel;
          bus.br_taken  = br;
          cyc(EXEC, sel);
          m_ret = m_ret + 16'd1;
          if (br) return;
          break;
        end
        cyc(EXEC, sel);
        if (i == TIMEOUT) begin
          m_code = 2'b10;
          fault_hold(idle);
          return;
        end
      end
    end
    noise(); bus.en = en_inc; cyc(INCPC, 4'b0);
    if (!en_inc) init_wait(idle);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1);
  end

  initial begin
    int r, f, d, ra;
    bus.en = 1'b0; bus.func = '0; bus.halt = 1'b0; bus.resume = 1'b0;
    bus.unit_done = '0; bus.br_taken = 1'b0;
    reset_seq(3);
    instr(1, 0, 1,   0, 0,  1, 0, 0);   // plain ALU op, done in first EXEC cycle
    instr(3, 0, 5,   1, 0,  1, 0, 0);   // branch taken after 5 EXEC cycles
    instr(0, 0, 0,   0, 0,  1, 0, 0);   // NOP
    instr(1, 1, 0,   0, 10, 1, 0, 0);   // halt, resume after 10 cycles
    instr(1, 0, 4,   0, 0,  1, 0, 0);   // other done bits ignored
    instr(2, 0, 200, 0, 0,  1, 0, 0);   // done on the last allowed cycle wins
    instr(2, 0, 2,   0, 0,  1, 0, 0);   // retired keeps counting
    instr(2, 0, 0,   0, 0,  1, 5, 0);   // watchdog timeout, then reset
    instr(5, 0, 0,   0, 0,  1, 3, 0);   // illegal func
    instr(2, 0, 1,   0, 0,  1, 0, 0);
    instr(1, 0, 0,   0, 0,  1, 2, 3);   // reset in third EXEC cycle
    instr(1, 0, 2,   0, 0,  0, 4, 0);   // en low at INCPC: back to INIT
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 19);
      d  = $urandom_range(1, 6);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : 0;
      if ($urandom_range(0, 39) == 0) d = 0;
      else if ($urandom_range(0, 39) == 0) d = TIMEOUT;
      if (r < 14)       f = $urandom_range(1, NF);
      else if (r < 17)  f = 0;
      else if (r == 17) f = $urandom_range(NF + 1, 7);
      else              f = $urandom_range(0, 7);
      instr(f, r >= 18, d, 1'($urandom), $urandom_range(0, 4),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 3), ra);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
